// File: rtl/decode_queue_pkg.sv
// decode_queue_pkg: shared definitions for the RV32I decode queue.
//   - RV32I major opcode constants
//   - op_e: 5-bit micro-op code (OpNop marks illegal/empty)
//   - dec_t: decoder output fields; entry_t: one queue slot (decode + illegal + PC)
package decode_queue_pkg;

    localparam logic [6:0] LD_OP    = 7'b0000011;
    localparam logic [6:0] ST_OP    = 7'b0100011;
    localparam logic [6:0] BR_OP    = 7'b1100011;
    localparam logic [6:0] BIN_OP   = 7'b0110011;
    localparam logic [6:0] IMM_OP   = 7'b0010011;
    localparam logic [6:0] JAL_OP   = 7'b1101111;
    localparam logic [6:0] JALR_OP  = 7'b1100111;
    localparam logic [6:0] AUIPC_OP = 7'b0010111;
    localparam logic [6:0] LUI_OP   = 7'b0110111;

    typedef enum logic [4:0] {
        OpNop, OpAdd, OpSub, OpSll, OpSlt, OpSltu, OpXor, OpSrl, OpSra, OpOr, OpAnd,
        OpBeq, OpBne, OpBlt, OpBge, OpBltu, OpBgeu,
        OpLb, OpLh, OpLw, OpLbu, OpLhu, OpSb, OpSh, OpSw,
        OpJal, OpJalr, OpLui, OpAuipc
    } op_e;

    typedef struct packed {
        op_e         op;
        logic        branch;
        logic        ls;
        logic        use_imm;
        logic        jalr;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } dec_t;

    typedef struct packed {
        dec_t        dec;
        logic        illegal;
        logic [31:0] pc;
    } entry_t;

endpackage

// File: rtl/decode_queue_if.sv
// decode_queue_if: fetch-side and dispatch-side handshakes of the decode queue.
//   master: producer/consumer side (drives in_*, out_ready)
//   slave : the queue (drives in_ready, out_*, count)
interface decode_queue_if
    import decode_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [31:0]      in_pc;
    logic             out_valid;
    logic             out_ready;
    op_e              out_op;
    logic             out_branch;
    logic             out_ls;
    logic             out_use_imm;
    logic             out_jalr;
    logic             out_illegal;
    logic [4:0]       out_rd;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [31:0]      out_imm;
    logic [31:0]      out_pc;
    logic [PTR_W:0]   count;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_op, out_branch, out_ls, out_use_imm, out_jalr,
               out_illegal, out_rd, out_rs1, out_rs2, out_imm, out_pc, count
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_op, out_branch, out_ls, out_use_imm, out_jalr,
               out_illegal, out_rd, out_rs1, out_rs2, out_imm, out_pc, count
    );

endinterface

// File: rtl/rv32i_decode_comb.sv
// rv32i_decode_comb: purely combinational RV32I decoder.
//   inst    : raw 32-bit instruction
//   dec     : decoded micro-op fields
//   illegal : instruction is not legal RV32I (dec then carries a NOP with zero imm)
module rv32i_decode_comb
    import decode_queue_pkg::*;
(
    input  logic [31:0] inst,
    output dec_t        dec,
    output logic        illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_sh;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_u  = {inst[31:12], 12'b0};
    assign imm_sh = {27'b0, inst[24:20]};

    always_comb begin
        dec     = '0;
        illegal = 1'b0;
        dec.op  = OpNop;
        dec.rd  = inst[11:7];
        dec.rs1 = inst[19:15];
        dec.rs2 = inst[24:20];

        case (opcode)
            BIN_OP: begin
                case (funct3)
                    3'b000:  dec.op = funct7[5] ? OpSub : OpAdd;
                    3'b001:  dec.op = OpSll;
                    3'b010:  dec.op = OpSlt;
                    3'b011:  dec.op = OpSltu;
                    3'b100:  dec.op = OpXor;
                    3'b101:  dec.op = funct7[5] ? OpSra : OpSrl;
                    3'b110:  dec.op = OpOr;
                    default: dec.op = OpAnd;
                endcase
                // The alternate funct7 only selects SUB and SRA.
                if (funct7 == 7'b0000000) begin
                    illegal = 1'b0;
                end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    illegal = 1'b0;
                end else begin
                    illegal = 1'b1;
                end
            end
            IMM_OP: begin
                dec.use_imm = 1'b1;
                dec.imm     = imm_i;
                case (funct3)
                    3'b000: dec.op = OpAdd;
                    3'b010: dec.op = OpSlt;
                    3'b011: dec.op = OpSltu;
                    3'b100: dec.op = OpXor;
                    3'b110: dec.op = OpOr;
                    3'b111: dec.op = OpAnd;
                    3'b001: begin
                        dec.op  = OpSll;
                        dec.imm = imm_sh;
                        illegal = (funct7 != 7'b0000000);
                    end
                    default: begin
                        dec.op  = funct7[5] ? OpSra : OpSrl;
                        dec.imm = imm_sh;
                        illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                    end
                endcase
            end
            LD_OP: begin
                dec.ls      = 1'b1;
                dec.use_imm = 1'b1;
                dec.imm     = imm_i;
                case (funct3)
                    3'b000:  dec.op = OpLb;
                    3'b001:  dec.op = OpLh;
                    3'b010:  dec.op = OpLw;
                    3'b100:  dec.op = OpLbu;
                    3'b101:  dec.op = OpLhu;
                    default: illegal = 1'b1;
                endcase
            end
            ST_OP: begin
                dec.ls      = 1'b1;
                dec.use_imm = 1'b1;
                dec.imm     = imm_s;
                case (funct3)
                    3'b000:  dec.op = OpSb;
                    3'b001:  dec.op = OpSh;
                    3'b010:  dec.op = OpSw;
                    default: illegal = 1'b1;
                endcase
            end
            BR_OP: begin
                dec.branch  = 1'b1;
                dec.use_imm = 1'b1;
                dec.imm     = imm_b;
                case (funct3)
                    3'b000:  dec.op = OpBeq;
                    3'b001:  dec.op = OpBne;
                    3'b100:  dec.op = OpBlt;
                    3'b101:  dec.op = OpBge;
                    3'b110:  dec.op = OpBltu;
                    3'b111:  dec.op = OpBgeu;
                    default: illegal = 1'b1;
                endcase
            end
            JAL_OP: begin
                dec.op      = OpJal;
                dec.use_imm = 1'b1;
                dec.imm     = imm_j;
            end
            JALR_OP: begin
                dec.op      = OpJalr;
                dec.jalr    = 1'b1;
                dec.use_imm = 1'b1;
                dec.imm     = imm_i;
                illegal     = (funct3 != 3'b000);
            end
            LUI_OP: begin
                dec.op      = OpLui;
                dec.use_imm = 1'b1;
                dec.imm     = imm_u;
            end
            AUIPC_OP: begin
                dec.op      = OpAuipc;
                dec.use_imm = 1'b1;
                dec.imm     = imm_u;
            end
            default: illegal = 1'b1;
        endcase

        // Illegal entries still travel down the pipe as inert NOPs so the ROB can trap on them.
        if (illegal) begin
            dec.op      = OpNop;
            dec.imm     = '0;
            dec.use_imm = 1'b0;
            dec.branch  = 1'b0;
            dec.ls      = 1'b0;
            dec.jalr    = 1'b0;
        end
    end

endmodule

// File: rtl/decode_queue.sv
// decode_queue: registered RV32I decode stage with a DEPTH-entry FIFO of decoded micro-ops.
//   clk_in   : clock
//   rst_in   : synchronous active-high reset (priority over flush)
//   flush_in : mispredict flush, empties the queue and drops same-cycle push/pop
//   bus      : fetch handshake (in_*), dispatch handshake (out_*), occupancy (count)
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           flush_in,
    decode_queue_if.slave  bus
);

    localparam int unsigned   PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    dec_t             in_dec;
    logic             in_illegal;
    entry_t           wr_entry;
    entry_t           head;
    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push, pop;

    rv32i_decode_comb u_decode (
        .inst    (bus.in_inst),
        .dec     (in_dec),
        .illegal (in_illegal)
    );

    assign wr_entry = '{dec: in_dec, illegal: in_illegal, pc: bus.in_pc};

    // Ready/valid come from registered occupancy only; a full queue never accepts.
    assign bus.in_ready  = (count_q != FULL_COUNT);
    assign bus.out_valid = (count_q != '0);

    assign push = bus.in_valid & bus.in_ready & ~flush_in;
    assign pop  = bus.out_valid & bus.out_ready & ~flush_in;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W + 1)'(1);
                2'b01:   count_d = count_q - (PTR_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is not reset; outputs are don't-care while out_valid is low.
    always_ff @(posedge clk_in) begin
        if (push) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign head            = mem_q[rd_ptr_q];
    assign bus.out_op      = head.dec.op;
    assign bus.out_branch  = head.dec.branch;
    assign bus.out_ls      = head.dec.ls;
    assign bus.out_use_imm = head.dec.use_imm;
    assign bus.out_jalr    = head.dec.jalr;
    assign bus.out_illegal = head.illegal;
    assign bus.out_rd      = head.dec.rd;
    assign bus.out_rs1     = head.dec.rs1;
    assign bus.out_rs2     = head.dec.rs2;
    assign bus.out_imm     = head.dec.imm;
    assign bus.out_pc      = head.pc;
    assign bus.count       = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed bench for decode_queue with a scoreboard of expected head entries.
module tb_decode_queue;
    import decode_queue_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int          NINST = 11;

    typedef struct packed {
        op_e         op;
        logic        illegal;
        logic        branch;
        logic        ls;
        logic        use_imm;
        logic        jalr;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    decode_queue_if #(.DEPTH(DEPTH)) bus ();

    decode_queue #(.DEPTH(DEPTH)) dut (
        .clk_in   (clk),
        .rst_in   (rst),
        .flush_in (flush),
        .bus      (bus)
    );

    exp_t        sb [$];
    int          mdl_cnt = 0;
    int          checks  = 0;
    int          errors  = 0;
    logic [31:0] insts [NINST];
    exp_t        exps  [NINST];

    function automatic exp_t mk(op_e op, logic ill, logic br, logic ls, logic ui, logic jr,
                                logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                logic [31:0] imm, logic [31:0] pc);
        exp_t e;
        e.op = op; e.illegal = ill; e.branch = br; e.ls = ls; e.use_imm = ui; e.jalr = jr;
        e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.pc = pc;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock of stimulus: drive inputs, check state against the model, advance the model.
    task automatic step(input logic iv, input logic [31:0] inst, input exp_t e,
                        input logic ordy, input logic fl, input logic rs);
        bit   do_push, do_pop;
        exp_t obs;
        bus.in_valid  = iv;
        bus.in_inst   = inst;
        bus.in_pc     = e.pc;
        bus.out_ready = ordy;
        flush         = fl;
        rst           = rs;
        chk("count", 128'(bus.count), 128'(mdl_cnt));
        chk("in_ready", 128'(bus.in_ready), 128'(mdl_cnt != DEPTH));
        chk("out_valid", 128'(bus.out_valid), 128'(mdl_cnt != 0));
        if (mdl_cnt != 0) begin
            obs = mk(bus.out_op, bus.out_illegal, bus.out_branch, bus.out_ls, bus.out_use_imm,
                     bus.out_jalr, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_imm, bus.out_pc);
            chk("head", 128'(obs), 128'(sb[0]));
        end
        do_push = iv && (mdl_cnt != DEPTH);
        do_pop  = ordy && (mdl_cnt != 0);
        @(posedge clk);
        #1;
        if (rs || fl) begin
            sb.delete();
            mdl_cnt = 0;
        end else begin
            if (do_pop)  void'(sb.pop_front());
            if (do_push) sb.push_back(e);
            mdl_cnt = mdl_cnt + int'(do_push) - int'(do_pop);
        end
    endtask

    initial begin
        insts[0]  = 32'hFFF10093; exps[0]  = mk(OpAdd,  0,0,0,1,0, 1,2,31, 32'hFFFFFFFF, 32'h100);
        insts[1]  = 32'h402081B3; exps[1]  = mk(OpSub,  0,0,0,0,0, 3,1,2,  32'h0,        32'h104);
        insts[2]  = 32'h008000EF; exps[2]  = mk(OpJal,  0,0,0,1,0, 1,0,8,  32'h8,        32'h108);
        insts[3]  = 32'h00003003; exps[3]  = mk(OpNop,  1,0,0,0,0, 0,0,0,  32'h0,        32'h10C);
        insts[4]  = 32'h0000007F; exps[4]  = mk(OpNop,  1,0,0,0,0, 0,0,0,  32'h0,        32'h110);
        insts[5]  = 32'h00208463; exps[5]  = mk(OpBeq,  0,1,0,1,0, 8,1,2,  32'h8,        32'h114);
        insts[6]  = 32'h0020A223; exps[6]  = mk(OpSw,   0,0,1,1,0, 4,1,2,  32'h4,        32'h118);
        insts[7]  = 32'h123452B7; exps[7]  = mk(OpLui,  0,0,0,1,0, 5,8,3,  32'h12345000, 32'h11C);
        insts[8]  = 32'h40315093; exps[8]  = mk(OpSra,  0,0,0,1,0, 1,2,3,  32'h3,        32'h120);
        insts[9]  = 32'h40311093; exps[9]  = mk(OpNop,  1,0,0,0,0, 1,2,3,  32'h0,        32'h124);
        insts[10] = 32'h000100E7; exps[10] = mk(OpJalr, 0,0,0,1,1, 1,2,0,  32'h0,        32'h128);

        bus.in_valid  = 1'b0;
        bus.in_inst   = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Streaming: each instruction is seen at the head one cycle after acceptance.
        for (int i = 0; i < NINST; i++) step(1'b1, insts[i], exps[i], 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, exps[0], 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, exps[0], 1'b1, 1'b0, 1'b0);

        // Fill to DEPTH, offer a 5th, then release: one pop, then push+pop, order across wrap.
        for (int i = 0; i < 4; i++) step(1'b1, insts[i], exps[i], 1'b0, 1'b0, 1'b0);
        step(1'b1, insts[4], exps[4], 1'b0, 1'b0, 1'b0);
        step(1'b1, insts[4], exps[4], 1'b1, 1'b0, 1'b0);
        step(1'b1, insts[4], exps[4], 1'b1, 1'b0, 1'b0);
        step(1'b1, insts[5], exps[5], 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, exps[0], 1'b1, 1'b0, 1'b0);

        // Flush with three queued and a same-cycle push/pop; the flushed-cycle entry must vanish.
        for (int i = 6; i < 9; i++) step(1'b1, insts[i], exps[i], 1'b0, 1'b0, 1'b0);
        step(1'b1, insts[9], exps[9], 1'b1, 1'b1, 1'b0);
        step(1'b0, '0, exps[0], 1'b0, 1'b0, 1'b0);
        step(1'b1, insts[10], exps[10], 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, exps[0], 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, exps[0], 1'b1, 1'b0, 1'b0);

        // Reset while full.
        for (int i = 0; i < 4; i++) step(1'b1, insts[i], exps[i], 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, exps[0], 1'b0, 1'b0, 1'b1);
        step(1'b1, insts[7], exps[7], 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, exps[0], 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, exps[0], 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Registered RV32I decode stage between instruction fetch and dispatch/reservation stations.
- Accepts raw instructions with PC over a valid/ready handshake and decodes them.
- Buffers decoded micro-ops in a parametrised FIFO, presented to dispatch over a second valid/ready handshake.
- Adds what the combinational decoder lacked: buffering, back-pressure, flush on mispredict, illegal-instruction detection, full default assignments (no latches).

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous active-high reset
- flush_in  input  1  mispredict flush; empties queue
- in_valid  input  1  fetch offers instruction
- in_ready  output  1  queue can accept
- in_inst  input  32  raw instruction
- in_pc  input  32  instruction PC
- out_valid  output  1  head entry valid
- out_ready  input  1  dispatch consumes head
- out_op  output  5  operation code (package enum)
- out_branch  output  1  conditional branch
- out_ls  output  1  load or store
- out_use_imm  output  1  second operand is immediate
- out_jalr  output  1  op is JALR
- out_illegal  output  1  instruction not legal RV32I
- out_rd, out_rs1, out_rs2  output  5 each  register fields
- out_imm  output  32  sign/zero-extended immediate
- out_pc  output  32  PC of head entry
- count  output  PTR_W+1  occupancy

Behaviour:
- Reset: pointers and count = 0; out_valid = 0, in_ready = 1. Entry storage is not reset; outputs mirror the head entry but are don't-care while out_valid = 0.
- Handshake:
  - Enqueue when in_valid & in_ready.
  - Dequeue when out_valid & out_ready.
  - in_ready = (count != DEPTH), computed from current state only. A full queue does not accept even if dequeuing that cycle.
- Latency: an instruction accepted in cycle N is visible at the head with out_valid = 1 in cycle N+1 if the queue was empty. No combinational path from in_* to out_*.
- Simultaneous enqueue and dequeue: count unchanged; both pointers advance; pointers wrap modulo DEPTH.
- Flush: flush_in = 1 clears pointers and count next cycle. Any enqueue or dequeue in the same cycle is discarded. Reset has priority over flush.
- Decode rules (combinational on in_inst, result stored at enqueue):
  - rd = [11:7], rs1 = [19:15], rs2 = [24:20] always.
  - out_ls = LOAD | STORE opcode.
  - out_branch = BRANCH opcode only.
  - out_jalr = (op == JALR).
  - OP (register-register): use_imm = 0. funct7 0000000 for all funct3; 0100000 is legal only with funct3 000 (SUB) or 101 (SRA). Anything else is illegal.
  - OP-IMM: I-imm sign-extended. Shifts (funct3 001/101) use zero-extended shamt [24:20]. [31:25] must be 0000000, or 0100000 for SRAI only; else illegal.
  - LOAD: funct3 in {000,001,010,100,101}, else illegal; I-imm.
  - STORE: funct3 in {000,001,010}, else illegal; S-imm.
  - BRANCH: funct3 010/011 illegal; B-imm with LSB 0.
  - JAL: J-imm. JALR: funct3 must be 000; I-imm.
  - LUI/AUIPC: imm = {[31:12], 12'b0}.
  - All non-OP formats set use_imm = 1.
  - Any other opcode is illegal.
  - Illegal entries carry op = NOP, imm = 0, use_imm = 0, branch = ls = jalr = 0, rd/rs fields unchanged. They are still queued, so the ROB can raise the exception.
- Every combinational decode output has a default assignment.

Decomposition:
- Shared package/header holds:
  - opcode constants (LD_OP, ST_OP, BR_OP, BIN_OP, IMM_OP, JAL_OP, JALR_OP, AUIPC_OP, LUI_OP);
  - the 5-bit op enum, adding NOP;
  - the decoded-entry struct/field widths.
- Sub-module rv32i_decode_comb: pure combinational decoder producing the entry plus illegal. The top level holds only the FIFO, handshakes and flush.

Test Plan:
- Reset, then in_inst = 0xFFF10093 (addi x1,x2,-1), pc = 0x100 → next cycle out_valid = 1, op = ADD, rd = 1, rs1 = 2, imm = 0xFFFFFFFF, use_imm = 1, out_pc = 0x100, illegal = 0.
- 0x402081B3 (sub x3,x1,x2) → op = SUB, use_imm = 0. 0x008000EF (jal x1,8) → op = JAL, imm = 8, jalr = 0, branch = 0.
- 0x00003003 (load funct3 011) and 0x0000007F (bad opcode) → illegal = 1, op = NOP, imm = 0; both still dequeue in order.
- out_ready = 0, push 4 instructions → count = 4, in_ready = 0. A 5th in_valid is not accepted. Set out_ready = 1 with in_valid held → exactly one pop and, next cycle, one push; FIFO order preserved across pointer wrap.
- Queue holding 3 entries, flush_in pulsed together with in_valid and out_ready → next cycle count = 0, out_valid = 0, and the flushed-cycle instruction never appears.
- rst_in asserted while the queue is full → next cycle count = 0, in_ready = 1, out_valid = 0.
